sd_req_arbiter: RTL and testbench

- Shares the single SD block-level interface (sd_lba, sd_rd, sd_wr, sd_ack, sd_buff_*) between two disk requesters (requester 0 = FDD controller, requester 1 = EDD/RAM-disk controller).
- Each requester posts sector read/write commands.
- The arbiter grants round-robin, drives the ARM-side request lines, and follows the sd_ack handshake.
- It routes sector-buffer traffic to the granted requester only, and reports completion or timeout.

---
 rtl/sd_req_arbiter.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sd_req_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter: shares the single SD block interface between two disk
// requesters (0 = FDD controller, 1 = EDD/RAM-disk controller).
// Commands are captured per requester, granted round-robin, run through the
// sd_ack handshake and finished with a one-cycle done (and err on timeout).
// Sector-buffer strobes are routed to the granted requester only.
module sd_req_arbiter #(
    parameter int TO_BITS = 24
) (
    input  logic        clk_sys,
    input  logic        reset,

    // requester 0 (FDD)
    input  logic [31:0] r0_lba,
    input  logic        r0_rd,
    input  logic        r0_wr,
    output logic        r0_busy,
    output logic        r0_done,
    output logic        r0_err,
    output logic        r0_buff_wr,
    input  logic [7:0]  r0_buff_din,

    // requester 1 (EDD / RAM disk)
    input  logic [31:0] r1_lba,
    input  logic        r1_rd,
    input  logic        r1_wr,
    output logic        r1_busy,
    output logic        r1_done,
    output logic        r1_err,
    output logic        r1_buff_wr,
    input  logic [7:0]  r1_buff_din,

    // shared buffer bus towards both requesters
    output logic [8:0]  buff_addr,
    output logic [7:0]  buff_dout,

    // mist_io side
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [1:0]         pend_q,    pend_d;     // command accepted, not yet finished
    logic [1:0]         op_wr_q,   op_wr_d;    // latched op per requester (1 = write)
    logic               grant_q,   grant_d;    // requester owning the SD interface
    logic               last_q,    last_d;     // requester served most recently
    logic               cur_wr_q,  cur_wr_d;   // op of the granted command
    logic [31:0]        sd_lba_q,  sd_lba_d;
    logic               sd_rd_q,   sd_rd_d;
    logic               sd_wr_q,   sd_wr_d;
    logic [1:0]         done_q,    done_d;
    logic [1:0]         err_q,     err_d;
    logic [TO_BITS-1:0] to_cnt_q,  to_cnt_d;

    // sd_ack comes from the SPI clock domain: two-flop synchroniser plus
    // one more flop holding the previous synchronised value for edges
    logic               ack_meta_q, ack_meta_d;
    logic               ack_sync_q, ack_sync_d;
    logic               ack_prev_q, ack_prev_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0]         strobe_s;      // any command strobe per requester
    logic [1:0]         wr_only_s;     // write strobe without read (read wins)
    logic               ack_rise_s;
    logic               ack_fall_s;
    logic               to_max_s;
    logic               in_xfer_s;     // buffer traffic belongs to the grant
    logic               sel_s;         // requester picked in IDLE

    assign strobe_s   = {r1_rd | r1_wr, r0_rd | r0_wr};
    assign wr_only_s  = {r1_wr & ~r1_rd, r0_wr & ~r0_rd};
    assign ack_rise_s = ack_sync_q & ~ack_prev_q;
    assign ack_fall_s = ~ack_sync_q & ack_prev_q;
    assign to_max_s   = (to_cnt_q == {TO_BITS{1'b1}});
    assign in_xfer_s  = (state_q == ST_REQ) || (state_q == ST_XFER);

    // Next values of the ack synchroniser chain
    always_comb begin
        ack_meta_d = sd_ack;
        ack_sync_d = ack_meta_q;
        ack_prev_d = ack_sync_q;
    end

    // Per-requester command capture; pending clears when its DONE cycle ends
    always_comb begin
        pend_d  = pend_q;
        op_wr_d = op_wr_q;
        for (int n = 0; n < 2; n++) begin
            if (strobe_s[n] && !pend_q[n]) begin
                pend_d[n]  = 1'b1;
                op_wr_d[n] = wr_only_s[n];
            end else if ((state_q == ST_DONE) && (grant_q == 1'(n))) begin
                pend_d[n]  = 1'b0;
                op_wr_d[n] = op_wr_q[n];
            end else begin
                pend_d[n]  = pend_q[n];
                op_wr_d[n] = op_wr_q[n];
            end
        end
    end

    // Round-robin pick: a lone pending requester wins, a tie goes to the
    // requester that was not served last
    always_comb begin
        sel_s = 1'b0;
        case (pend_q)
            2'b01:   sel_s = 1'b0;
            2'b10:   sel_s = 1'b1;
            2'b11:   sel_s = ~last_q;
            default: sel_s = 1'b0;
        endcase
    end

    // Arbitration FSM: next state, request lines, timeout and completion
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cur_wr_d = cur_wr_q;
        sd_lba_d = sd_lba_q;
        sd_rd_d  = 1'b0;
        sd_wr_d  = 1'b0;
        to_cnt_d = {TO_BITS{1'b0}};
        done_d   = 2'b00;
        err_d    = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (pend_q != 2'b00) begin
                    grant_d  = sel_s;
                    cur_wr_d = op_wr_q[sel_s];
                    sd_lba_d = sel_s ? r1_lba : r0_lba;
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (ack_rise_s) begin
                    // ARM took the command: release the request line
                    state_d = ST_XFER;
                end else if (to_max_s) begin
                    // no ack in time: give up and report an error
                    state_d          = ST_DONE;
                    done_d[grant_q]  = 1'b1;
                    err_d[grant_q]   = 1'b1;
                end else begin
                    state_d  = ST_REQ;
                    to_cnt_d = to_cnt_q + {{(TO_BITS-1){1'b0}}, 1'b1};
                    sd_rd_d  = ~cur_wr_q;
                    sd_wr_d  = cur_wr_q;
                end
            end

            ST_XFER: begin
                // the ARM always finishes the sector, so no timeout here
                if (ack_fall_s) begin
                    state_d         = ST_DONE;
                    done_d[grant_q] = 1'b1;
                end else begin
                    state_d = ST_XFER;
                end
            end

            ST_DONE: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update with synchronous reset; last grant resets to 1 so
    // requester 0 wins the first tie
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_q     <= 2'b00;
            op_wr_q    <= 2'b00;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            cur_wr_q   <= 1'b0;
            sd_lba_q   <= 32'h0000_0000;
            sd_rd_q    <= 1'b0;
            sd_wr_q    <= 1'b0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            to_cnt_q   <= {TO_BITS{1'b0}};
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            op_wr_q    <= op_wr_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cur_wr_q   <= cur_wr_d;
            sd_lba_q   <= sd_lba_d;
            sd_rd_q    <= sd_rd_d;
            sd_wr_q    <= sd_wr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            ack_meta_q <= ack_meta_d;
            ack_sync_q <= ack_sync_d;
            ack_prev_q <= ack_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // busy covers the pending window, which ends with the DONE cycle, so it
    // drops the cycle after the done pulse
    assign r0_busy = pend_q[0];
    assign r1_busy = pend_q[1];
    assign r0_done = done_q[0];
    assign r1_done = done_q[1];
    assign r0_err  = err_q[0];
    assign r1_err  = err_q[1];

    assign sd_lba  = sd_lba_q;
    assign sd_rd   = sd_rd_q;
    assign sd_wr   = sd_wr_q;

    // Buffer writes reach only the granted requester and only while a
    // command is in flight; stray traffic (e.g. config) is dropped
    assign r0_buff_wr = sd_buff_wr & ~grant_q & in_xfer_s;
    assign r1_buff_wr = sd_buff_wr &  grant_q & in_xfer_s;

    // Read data follows the grant in every state so the ARM can prefetch
    // byte 0 as soon as it acks
    assign sd_buff_din = grant_q ? r1_buff_din : r0_buff_din;

    assign buff_addr = sd_buff_addr;
    assign buff_dout = sd_buff_dout;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomised self-checking bench for sd_req_arbiter. A transaction-level
// model (pending set, round-robin last grant, expected done/err counts)
// predicts which requester is served and with what address/op.
module tb_sd_req_arbiter;

    localparam int TO_BITS = 4;
    localparam int TO_LEN  = 15;   // cycles sd_rd stays high before timeout

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [31:0] r0_lba, r1_lba;
    logic        r0_rd, r0_wr, r1_rd, r1_wr;
    logic        r0_busy, r0_done, r0_err, r0_buff_wr;
    logic        r1_busy, r1_done, r1_err, r1_buff_wr;
    logic [7:0]  r0_buff_din, r1_buff_din;
    logic [8:0]  buff_addr;
    logic [7:0]  buff_dout;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr, sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter #(.TO_BITS(TO_BITS)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .r0_lba(r0_lba), .r0_rd(r0_rd), .r0_wr(r0_wr), .r0_busy(r0_busy),
        .r0_done(r0_done), .r0_err(r0_err), .r0_buff_wr(r0_buff_wr), .r0_buff_din(r0_buff_din),
        .r1_lba(r1_lba), .r1_rd(r1_rd), .r1_wr(r1_wr), .r1_busy(r1_busy),
        .r1_done(r1_done), .r1_err(r1_err), .r1_buff_wr(r1_buff_wr), .r1_buff_din(r1_buff_din),
        .buff_addr(buff_addr), .buff_dout(buff_dout),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // cycle counter and independent done/err pulse counters
    int cyc = 0;
    int done_cnt[2] = '{0, 0};
    int err_cnt[2]  = '{0, 0};
    always @(posedge clk_sys) cyc <= cyc + 1;
    always @(negedge clk_sys) begin
        if (r0_done) done_cnt[0] <= done_cnt[0] + 1;
        if (r1_done) done_cnt[1] <= done_cnt[1] + 1;
        if (r0_err)  err_cnt[0]  <= err_cnt[0] + 1;
        if (r1_err)  err_cnt[1]  <= err_cnt[1] + 1;
    end

    // reference model
    bit          mpend[2];
    bit          mwr[2];
    logic [31:0] mlba[2];
    logic [7:0]  mdin[2];
    int          mlast = 1;
    int          exp_done[2] = '{0, 0};
    int          exp_err[2]  = '{0, 0};
    int          ack_drop_cyc = -1;

    function automatic logic get_done(input int w); return (w == 1) ? r1_done : r0_done; endfunction
    function automatic logic get_err(input int w);  return (w == 1) ? r1_err  : r0_err;  endfunction
    function automatic logic get_busy(input int w); return (w == 1) ? r1_busy : r0_busy; endfunction
    function automatic logic get_bwr(input int w);  return (w == 1) ? r1_buff_wr : r0_buff_wr; endfunction

    // requester the model expects to be granted next
    function automatic int pick();
        if (mpend[0] && mpend[1]) return 1 - mlast;
        return mpend[1] ? 1 : 0;
    endfunction

    task automatic set_req(input int w, input logic [31:0] lba, input logic [7:0] din);
        if (w == 1) begin r1_lba = lba; r1_buff_din = din; end
        else        begin r0_lba = lba; r0_buff_din = din; end
    endtask

    // op: 0 = read, 1 = write, 2 = read and write together (read wins)
    task automatic strobe(input bit s0, input int op0, input bit s1, input int op1);
        if (s0) begin r0_rd = (op0 != 1); r0_wr = (op0 != 0); end
        if (s1) begin r1_rd = (op1 != 1); r1_wr = (op1 != 0); end
        if (s0 && !mpend[0]) begin mpend[0] = 1'b1; mwr[0] = (op0 == 1); mlba[0] = r0_lba; mdin[0] = r0_buff_din; end
        if (s1 && !mpend[1]) begin mpend[1] = 1'b1; mwr[1] = (op1 == 1); mlba[1] = r1_lba; mdin[1] = r1_buff_din; end
        tick();
        r0_rd = 1'b0; r0_wr = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0;
        if (s0) check_eq("busy0_after_strobe", r0_busy, 1);
        if (s1) check_eq("busy1_after_strobe", r1_busy, 1);
    endtask

    // Run one granted command to completion and check it against the model
    task automatic serve(input int who, input bit to, input int nbytes, input bit restrobe, input bit late);
        int n, hi, c_me, c_oth, din_bad, pass_bad, oth;
        logic [7:0] d;
        oth = 1 - who;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 12) begin tick(); n++; end
        check_eq("req_latency", n, 2);
        if (!(sd_rd || sd_wr)) begin mpend[who] = 1'b0; return; end
        check_eq("sd_lba", sd_lba, mlba[who]);
        check_eq("sd_rd", sd_rd, !mwr[who]);
        check_eq("sd_wr", sd_wr, mwr[who]);
        check_eq("busy_in_req", get_busy(who), 1);
        check_eq("din_in_req", sd_buff_din, mdin[who]);
        if (ack_drop_cyc >= 0) begin
            check_eq("idle_gap_ok", (cyc - ack_drop_cyc) >= 3, 1);
            ack_drop_cyc = -1;
        end
        if (to) begin
            hi = 1;
            while (hi < 40) begin
                tick();
                if (sd_rd || sd_wr) hi++;
                else break;
            end
            check_eq("timeout_len", hi, TO_LEN);
            check_eq("to_done", get_done(who), 1);
            check_eq("to_err", get_err(who), 1);
            check_eq("to_other_done", get_done(oth), 0);
            exp_err[who]++;
        end else begin
            repeat ($urandom_range(0, 3)) tick();
            sd_ack = 1'b1;
            n = 0;
            while ((sd_rd || sd_wr) && n < 10) begin tick(); n++; end
            check_eq("ack_drop_within_3", (n >= 1) && (n <= 3), 1);
            if (restrobe) strobe(who == 0, $urandom_range(0, 2), who == 1, $urandom_range(0, 2));
            if (late && !mpend[oth]) begin
                set_req(oth, $urandom, 8'($urandom));
                strobe(oth == 0, $urandom_range(0, 2), oth == 1, $urandom_range(0, 2));
            end
            c_me = 0; c_oth = 0; din_bad = 0; pass_bad = 0;
            for (int i = 0; i < nbytes; i++) begin
                d = 8'($urandom);
                sd_buff_wr = 1'b1; sd_buff_addr = 9'(i); sd_buff_dout = d;
                #1;
                if (get_bwr(who)) c_me++;
                if (get_bwr(oth)) c_oth++;
                if (buff_addr !== 9'(i) || buff_dout !== d) pass_bad++;
                if (sd_buff_din !== mdin[who]) din_bad++;
                tick();
            end
            sd_buff_wr = 1'b0;
            check_eq("buff_wr_granted", c_me, nbytes);
            check_eq("buff_wr_other", c_oth, 0);
            check_eq("buff_passthru_bad", pass_bad, 0);
            check_eq("buff_din_bad", din_bad, 0);
            sd_ack = 1'b0;
            ack_drop_cyc = cyc;
            n = 0;
            while (!get_done(who) && n < 12) begin tick(); n++; end
            check_eq("done", get_done(who), 1);
            check_eq("err_clean", get_err(who), 0);
            check_eq("other_done", get_done(oth), 0);
        end
        check_eq("busy_during_done", get_busy(who), 1);
        tick();
        check_eq("done_width", get_done(who), 0);
        check_eq("busy_after_done", get_busy(who), 0);
        mpend[who] = 1'b0;
        mlast = who;
        exp_done[who]++;
    endtask

    // Strobe one or both requesters, serve everything pending, check idle
    task automatic run_group(input bit s0, input int op0, input logic [31:0] lba0, input logic [7:0] din0,
                             input bit s1, input int op1, input logic [31:0] lba1, input logic [7:0] din1,
                             input bit to, input int nbytes, input bit restrobe, input bit late);
        int w, guard;
        bit first;
        if (s0) set_req(0, lba0, din0);
        if (s1) set_req(1, lba1, din1);
        strobe(s0, op0, s1, op1);
        first = 1'b1;
        guard = 0;
        while ((mpend[0] || mpend[1]) && guard < 4) begin
            w = pick();
            serve(w, first ? to : 1'b0, nbytes, first ? restrobe : 1'b0, first ? late : 1'b0);
            first = 1'b0;
            guard++;
        end
        // stray buffer write while idle must be dropped
        sd_buff_wr = 1'b1;
        #1;
        check_eq("idle_bwr0", r0_buff_wr, 0);
        check_eq("idle_bwr1", r1_buff_wr, 0);
        tick();
        sd_buff_wr = 1'b0;
        check_eq("lba_hold", sd_lba, mlba[mlast]);
        repeat (3) tick();
        check_eq("idle_no_req", sd_rd || sd_wr, 0);
    endtask

    initial begin
        int mode, a, base0, base1, n;
        bit to;
        reset = 1'b1;
        r0_lba = 32'h0; r1_lba = 32'h0; r0_rd = 1'b0; r0_wr = 1'b0; r1_rd = 1'b0; r1_wr = 1'b0;
        r0_buff_din = 8'h00; r1_buff_din = 8'h00; sd_ack = 1'b0;
        sd_buff_addr = 9'h000; sd_buff_dout = 8'h00; sd_buff_wr = 1'b0;
        mpend[0] = 1'b0; mpend[1] = 1'b0;
        repeat (3) tick();
        check_eq("rst_sd_rd", sd_rd, 0);
        check_eq("rst_sd_wr", sd_wr, 0);
        check_eq("rst_sd_lba", sd_lba, 0);
        check_eq("rst_busy0", r0_busy, 0);
        check_eq("rst_busy1", r1_busy, 0);
        check_eq("rst_done", {r1_done, r0_done}, 0);
        check_eq("rst_err", {r1_err, r0_err}, 0);
        check_eq("rst_bwr", {r1_buff_wr, r0_buff_wr}, 0);
        reset = 1'b0;
        tick();

        // directed scenarios
        run_group(1'b1, 0, 32'h0000_0123, 8'h3C, 1'b0, 0, 32'h0, 8'h00, 1'b0, 512, 1'b0, 1'b0);
        run_group(1'b0, 0, 32'h0, 8'h00, 1'b1, 1, 32'h0000_0040, 8'hA5, 1'b0, 16, 1'b0, 1'b0);
        run_group(1'b1, 0, 32'h0000_1000, 8'h11, 1'b1, 0, 32'h0000_2000, 8'h22, 1'b0, 8, 1'b0, 1'b0);
        run_group(1'b1, 0, 32'h0000_3000, 8'h33, 1'b1, 0, 32'h0000_4000, 8'h44, 1'b0, 8, 1'b0, 1'b0);
        run_group(1'b1, 0, 32'h0000_5555, 8'h55, 1'b0, 0, 32'h0, 8'h00, 1'b1, 4, 1'b0, 1'b0);
        run_group(1'b1, 2, 32'h0000_6666, 8'h66, 1'b0, 0, 32'h0, 8'h00, 1'b0, 4, 1'b1, 1'b0);

        // randomised traffic
        for (int it = 0; it < 30; it++) begin
            mode = $urandom_range(0, 3);
            to = ($urandom_range(0, 4) == 0);
            case (mode)
                0: run_group(1'b1, $urandom_range(0, 2), $urandom, 8'($urandom), 1'b0, 0, 32'h0, 8'h00,
                             to, $urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b0);
                1: run_group(1'b0, 0, 32'h0, 8'h00, 1'b1, $urandom_range(0, 2), $urandom, 8'($urandom),
                             to, $urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b0);
                2: run_group(1'b1, $urandom_range(0, 2), $urandom, 8'($urandom), 1'b1, $urandom_range(0, 2), $urandom, 8'($urandom),
                             to, $urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b0);
                default: begin
                    a = $urandom_range(0, 1);
                    run_group(a == 0, $urandom_range(0, 2), $urandom, 8'($urandom), a == 1, $urandom_range(0, 2), $urandom, 8'($urandom),
                              1'b0, $urandom_range(1, 24), 1'b0, 1'b1);
                end
            endcase
        end

        // reset in the middle of a transfer
        set_req(0, 32'h0000_7777, 8'h77);
        strobe(1'b1, 0, 1'b0, 0);
        n = 0;
        while (!sd_rd && n < 12) begin tick(); n++; end
        check_eq("mid_rst_req_seen", sd_rd, 1);
        sd_ack = 1'b1;
        n = 0;
        while (sd_rd && n < 12) begin tick(); n++; end
        check_eq("mid_rst_in_xfer", sd_rd, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check_eq("mrst_sd_rd", sd_rd, 0);
        check_eq("mrst_sd_wr", sd_wr, 0);
        check_eq("mrst_sd_lba", sd_lba, 0);
        check_eq("mrst_busy", {r1_busy, r0_busy}, 0);
        check_eq("mrst_done", {r1_done, r0_done}, 0);
        check_eq("mrst_err", {r1_err, r0_err}, 0);
        check_eq("mrst_bwr", {r1_buff_wr, r0_buff_wr}, 0);
        reset = 1'b0;
        mpend[0] = 1'b0; mpend[1] = 1'b0; mlast = 1; ack_drop_cyc = -1;
        base0 = done_cnt[0]; base1 = done_cnt[1];
        repeat (3) tick();
        sd_ack = 1'b0;
        repeat (10) tick();
        check_eq("mrst_no_done0", done_cnt[0], base0);
        check_eq("mrst_no_done1", done_cnt[1], base1);
        check_eq("mrst_no_req", sd_rd || sd_wr, 0);
        run_group(1'b0, 0, 32'h0, 8'h00, 1'b1, 0, 32'h0000_0999, 8'h99, 1'b0, 8, 1'b0, 1'b0);

        tick();
        check_eq("done_count0", done_cnt[0], exp_done[0]);
        check_eq("done_count1", done_cnt[1], exp_done[1]);
        check_eq("err_count0", err_cnt[0], exp_err[0]);
        check_eq("err_count1", err_cnt[1], exp_err[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
